// File: rtl/char_vertical_motion.sv
// char_vertical_motion: per-character vertical physics.
// Owns y position and signed vertical velocity, and walks the GROUND / RISE /
// FALL / DROP state machine once per frame_tick using the OR-ed platform
// touch flag supplied by the collision checkers.
// Optional feature macro: DOUBLE_JUMP_EN (one extra jump per airborne period).
module char_vertical_motion #(
    parameter int HEIGHT      = 30,
    parameter int GRAVITY     = 1,
    parameter int JUMP_V      = 12,
    parameter int MAX_FALL    = 8,
    parameter int FLOOR_Y     = 420,
    parameter int RESET_Y     = 40,
    parameter int DROP_FRAMES = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              jump_btn,
    input  logic              down_btn,
    input  logic              touching,
    input  logic [9:0]        plat_top_y,
    output logic [9:0]        y_pos,
    output logic [9:0]        next_y,
    output logic signed [7:0] vy,
    output logic              grounded
);

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_RISE,
        ST_FALL,
        ST_DROP
    } state_t;

    localparam logic signed [10:0] FLOOR_S    = 11'(FLOOR_Y);
    localparam logic signed [10:0] SPRITE_H2  = 11'(2 * HEIGHT);
    localparam logic [9:0]         FLOOR_P    = 10'(FLOOR_Y);
    localparam logic [9:0]         RESET_P    = 10'(RESET_Y);
    localparam logic signed [7:0]  GRAV_V     = 8'(GRAVITY);
    localparam logic signed [7:0]  JUMP_VEL   = 8'(-JUMP_V);
    localparam logic signed [7:0]  MAX_FALL_V = 8'(MAX_FALL);
    localparam logic [7:0]         DROP_P     = 8'(DROP_FRAMES);

    state_t             state;
    logic [7:0]         drop_cnt;
    logic               jump_btn_d;
    logic               jump_latch;
    logic               jump_fire;
    logic               air_jump_go;
    logic signed [10:0] sum_y;
    logic signed [10:0] snap_y;
    logic [9:0]         snap_pos;
    logic signed [7:0]  vy_inc;
    logic signed [7:0]  vy_fall;

    // Candidate position, snap target and next-velocity arithmetic
    always_comb begin
        sum_y  = $signed({1'b0, y_pos}) + $signed({{3{vy[7]}}, vy});
        snap_y = $signed({1'b0, plat_top_y}) - SPRITE_H2;
        if (state == ST_GROUND)
            next_y = y_pos + 10'd1;
        else if (sum_y < 11'sd0)
            next_y = '0;
        else if (sum_y > FLOOR_S)
            next_y = FLOOR_P;
        else
            next_y = sum_y[9:0];
        snap_pos = (snap_y < 11'sd0) ? '0 : snap_y[9:0];
        vy_inc   = vy + GRAV_V;
        vy_fall  = (vy_inc > MAX_FALL_V) ? MAX_FALL_V : vy_inc;
    end

    // An edge arriving on the tick cycle itself is consumed by that tick
    assign jump_fire = jump_latch | (jump_btn & ~jump_btn_d);

    // Jump edge capture between frame ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_btn_d <= 1'b0;
            jump_latch <= 1'b0;
        end else begin
            jump_btn_d <= jump_btn;
            if (frame_tick)
                jump_latch <= 1'b0;
            else if (jump_btn && !jump_btn_d)
                jump_latch <= 1'b1;
        end
    end

`ifdef DOUBLE_JUMP_EN
    logic air_jump_used;

    assign air_jump_go = frame_tick && (state != ST_GROUND) && jump_fire && !air_jump_used;

    // Single air jump allowance, re-armed while standing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            air_jump_used <= 1'b0;
        else if (state == ST_GROUND)
            air_jump_used <= 1'b0;
        else if (air_jump_go)
            air_jump_used <= 1'b1;
    end
`else
    assign air_jump_go = 1'b0;
`endif

    // Per-frame vertical state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FALL;
            y_pos    <= RESET_P;
            vy       <= '0;
            grounded <= 1'b0;
            drop_cnt <= '0;
        end else if (frame_tick) begin
            if (air_jump_go) begin
                vy       <= JUMP_VEL;
                state    <= ST_RISE;
                grounded <= 1'b0;
                drop_cnt <= '0;
            end else begin
                case (state)
                    ST_GROUND: begin
                        if (jump_fire) begin
                            vy       <= JUMP_VEL;
                            state    <= ST_RISE;
                            grounded <= 1'b0;
                        end else if (down_btn && (y_pos < FLOOR_P)) begin
                            vy       <= 8'sd1;
                            drop_cnt <= DROP_P;
                            state    <= ST_DROP;
                            grounded <= 1'b0;
                        end else if (!touching && (y_pos < FLOOR_P)) begin
                            vy       <= '0;
                            state    <= ST_FALL;
                            grounded <= 1'b0;
                        end
                    end
                    ST_RISE: begin
                        y_pos <= next_y;
                        vy    <= vy_inc;
                        if (!vy_inc[7])
                            state <= ST_FALL;
                    end
                    ST_FALL: begin
                        if (touching) begin
                            y_pos    <= snap_pos;
                            vy       <= '0;
                            state    <= ST_GROUND;
                            grounded <= 1'b1;
                        end else if (next_y == FLOOR_P) begin
                            y_pos    <= FLOOR_P;
                            vy       <= '0;
                            state    <= ST_GROUND;
                            grounded <= 1'b1;
                        end else begin
                            y_pos <= next_y;
                            vy    <= vy_fall;
                        end
                    end
                    ST_DROP: begin
                        if (next_y == FLOOR_P) begin
                            y_pos    <= FLOOR_P;
                            vy       <= '0;
                            drop_cnt <= '0;
                            state    <= ST_GROUND;
                            grounded <= 1'b1;
                        end else begin
                            y_pos    <= next_y;
                            vy       <= vy_fall;
                            drop_cnt <= drop_cnt - 8'd1;
                            // Leave DROP on the tick that spends the last masked frame
                            if (drop_cnt <= 8'd1)
                                state <= ST_FALL;
                        end
                    end
                    default: begin
                        state <= ST_FALL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_char_vertical_motion.sv
// Self-checking bench for char_vertical_motion: directed scenarios followed by
// randomized frames, all compared against a frame-level behavioural model.
module tb_char_vertical_motion;

    logic              clk;
    logic              rst_n;
    logic              frame_tick;
    logic              jump_btn;
    logic              down_btn;
    logic              touching;
    logic [9:0]        plat_top_y;
    logic [9:0]        y_pos;
    logic [9:0]        next_y;
    logic signed [7:0] vy;
    logic              grounded;

`ifdef DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    localparam int M_GROUND = 0;
    localparam int M_RISE   = 1;
    localparam int M_FALL   = 2;
    localparam int M_DROP   = 3;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_y, m_vy, m_mode, m_drop_left;
    bit m_used, m_pend;

    char_vertical_motion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .jump_btn   (jump_btn),
        .down_btn   (down_btn),
        .touching   (touching),
        .plat_top_y (plat_top_y),
        .y_pos      (y_pos),
        .next_y     (next_y),
        .vy         (vy),
        .grounded   (grounded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int model_cand();
        if (m_mode == M_GROUND) return m_y + 1;
        return clampi(m_y + m_vy, 0, 420);
    endfunction

    task automatic model_reset();
        m_y = 40; m_vy = 0; m_mode = M_FALL; m_drop_left = 0; m_used = 0; m_pend = 0;
    endtask

    task automatic model_land(input int y);
        m_y = y; m_vy = 0; m_mode = M_GROUND;
    endtask

    task automatic model_step(input bit t, input int p, input bit d);
        int  cand;
        bit  j;
        cand   = model_cand();
        j      = m_pend;
        m_pend = 0;
        if (DJ && m_mode != M_GROUND && j && !m_used) begin
            m_vy = -12; m_mode = M_RISE; m_used = 1;
        end else begin
            case (m_mode)
                M_GROUND: begin
                    if (j) begin
                        m_vy = -12; m_mode = M_RISE;
                    end else if (d && m_y < 420) begin
                        m_vy = 1; m_mode = M_DROP; m_drop_left = 10;
                    end else if (!t && m_y < 420) begin
                        m_vy = 0; m_mode = M_FALL;
                    end
                end
                M_RISE: begin
                    m_y  = cand;
                    m_vy = m_vy + 1;
                    if (m_vy >= 0) m_mode = M_FALL;
                end
                M_FALL: begin
                    if (t) model_land(clampi(p - 60, 0, 1023));
                    else if (cand == 420) model_land(420);
                    else begin
                        m_y  = cand;
                        m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
                    end
                end
                default: begin
                    if (cand == 420) model_land(420);
                    else begin
                        m_y  = cand;
                        m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
                        m_drop_left--;
                        if (m_drop_left == 0) m_mode = M_FALL;
                    end
                end
            endcase
        end
        if (m_mode == M_GROUND) m_used = 0;
    endtask

    // One video frame: set inputs, optional one-cycle jump pulse, idle check, tick, post check
    task automatic frame(input bit t, input int p, input bit d, input bit j);
        @(negedge clk);
        touching   = t;
        plat_top_y = 10'(p);
        down_btn   = d;
        jump_btn   = j;
        if (j) m_pend = 1;
        @(negedge clk);
        jump_btn = 1'b0;
        chk("hold_y", y_pos, m_y);
        chk("hold_vy", vy, m_vy);
        chk("pre_next_y", next_y, model_cand());
        frame_tick = 1'b1;
        model_step(t, p, d);
        @(negedge clk);
        frame_tick = 1'b0;
        chk("y_pos", y_pos, m_y);
        chk("vy", vy, m_vy);
        chk("grounded", grounded, (m_mode == M_GROUND) ? 1 : 0);
        chk("next_y", next_y, model_cand());
    endtask

    task automatic fall_to_ground(input int budget);
        int n;
        n = 0;
        while (m_mode != M_GROUND && n < budget) begin
            frame(1'b0, 0, 1'b0, 1'b0);
            n++;
        end
        chk("land_within_budget", (m_mode == M_GROUND) ? 1 : 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; jump_btn = 1'b0; down_btn = 1'b0;
        touching = 1'b0; plat_top_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_y", y_pos, 40);
        chk("rst_vy", vy, 0);
        chk("rst_grounded", grounded, 0);
        chk("rst_next_y", next_y, 40);
        rst_n = 1'b1;

        // Free fall from reset to the floor with terminal velocity
        for (int i = 1; i <= 10; i++) begin
            frame(1'b0, 0, 1'b0, 1'b0);
            chk("t1_vy_ramp", vy, (i < 8) ? i : 8);
        end
        fall_to_ground(60);
        chk("t1_floor_y", y_pos, 420);
        chk("t1_floor_grounded", grounded, 1);

        // Jump off the floor, then land on a platform at 215
        frame(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && m_mode != M_FALL; i++) frame(1'b0, 0, 1'b0, 1'b0);
        frame(1'b0, 0, 1'b0, 1'b0);
        frame(1'b1, 215, 1'b0, 1'b0);
        chk("t2_snap_y", y_pos, 155);
        chk("t2_snap_vy", vy, 0);
        chk("t2_snap_grounded", grounded, 1);

        // Full jump arc from y=155
        frame(1'b1, 215, 1'b0, 1'b1);
        chk("t3_launch_vy", vy, -12);
        chk("t3_launch_y", y_pos, 155);
        repeat (12) frame(1'b0, 0, 1'b0, 1'b0);
        chk("t3_apex_vy", vy, 0);
        chk("t3_apex_y", y_pos, 77);
        chk("t3_apex_grounded", grounded, 0);
        frame(1'b1, 215, 1'b0, 1'b0);
        chk("t3_reland_y", y_pos, 155);

        // Drop-through with touching held high
        frame(1'b1, 215, 1'b1, 1'b0);
        chk("t4_drop_vy", vy, 1);
        chk("t4_drop_grounded", grounded, 0);
        repeat (10) frame(1'b1, 215, 1'b0, 1'b0);
        chk("t4_after_drop_y", y_pos, 207);
        chk("t4_after_drop_grounded", grounded, 0);
        frame(1'b1, 300, 1'b0, 1'b0);
        chk("t4_land_y", y_pos, 240);
        chk("t4_land_grounded", grounded, 1);

        // Walk off an edge, reland, then jump+down together
        frame(1'b0, 0, 1'b0, 1'b0);
        chk("t5_walkoff_vy", vy, 0);
        chk("t5_walkoff_grounded", grounded, 0);
        frame(1'b1, 300, 1'b0, 1'b0);
        frame(1'b1, 300, 1'b1, 1'b1);
        chk("t5_jump_wins_vy", vy, -12);
        chk("t5_jump_wins_grounded", grounded, 0);

        // Airborne jump presses
        repeat (15) frame(1'b0, 0, 1'b0, 1'b0);
        chk("t6_pre_vy", vy, 3);
        frame(1'b0, 0, 1'b0, 1'b1);
        chk("t6_air_jump_vy", vy, DJ ? -12 : 4);
        frame(1'b0, 0, 1'b0, 1'b1);
        chk("t6_third_press_vy", vy, DJ ? -11 : 5);
        fall_to_ground(100);

        // Randomized frames
        for (int i = 0; i < 300; i++) begin
            bit t, d, j;
            int p;
            t = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0);
            j = ($urandom_range(0, 5) == 0);
            p = int'($urandom_range(40, 480));
            frame(t, p, d, j);
        end

        // Reset asserted mid-frame while rising
        fall_to_ground(100);
        frame(1'b1, 0, 1'b0, 1'b1);
        @(negedge clk);
        frame_tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_y", y_pos, 40);
        chk("midrst_vy", vy, 0);
        chk("midrst_grounded", grounded, 0);
        @(negedge clk);
        frame_tick = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Snap clamp and rising through the top edge
        frame(1'b1, 70, 1'b0, 1'b0);
        chk("top_snap_y", y_pos, 10);
        frame(1'b1, 70, 1'b0, 1'b1);
        frame(1'b0, 0, 1'b0, 1'b0);
        chk("top_clamp_y", y_pos, 0);
        chk("top_clamp_vy", vy, -11);
        frame(1'b0, 0, 1'b0, 1'b0);
        chk("top_hold_y", y_pos, 0);
        chk("top_hold_vy", vy, -10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
